// File: rtl/vga_timing_gen.sv
// VGA raster timing: pixel/line counters plus one registered, mutually aligned output stage.
// Optional macro VGA_FRAME_COUNT_EN adds a 16-bit frame counter; otherwise frame_count is tied to 0.
module vga_timing_gen #(
   parameter int H_VISIBLE = 640,
   parameter int H_FP      = 16,
   parameter int H_SYNC    = 96,
   parameter int H_BP      = 48,
   parameter int V_VISIBLE = 480,
   parameter int V_FP      = 10,
   parameter int V_SYNC    = 2,
   parameter int V_BP      = 33
) (
   input  logic        vga_clk,
   input  logic        reset,
   input  logic        pix_en,
   output logic        hs,
   output logic        vs,
   output logic        blank,
   output logic [9:0]  DrawX,
   output logic [9:0]  DrawY,
   output logic        frame_start,
   output logic [15:0] frame_count
);

   // Compared at 11 bits so a 1024-wide total or sync end does not alias to 0.
   localparam logic [10:0] H_TOTAL  = 11'(H_VISIBLE + H_FP + H_SYNC + H_BP);
   localparam logic [10:0] V_TOTAL  = 11'(V_VISIBLE + V_FP + V_SYNC + V_BP);
   localparam logic [10:0] H_VIS    = 11'(H_VISIBLE);
   localparam logic [10:0] V_VIS    = 11'(V_VISIBLE);
   localparam logic [10:0] HS_START = 11'(H_VISIBLE + H_FP);
   localparam logic [10:0] HS_END   = 11'(H_VISIBLE + H_FP + H_SYNC);
   localparam logic [10:0] VS_START = 11'(V_VISIBLE + V_FP);
   localparam logic [10:0] VS_END   = 11'(V_VISIBLE + V_FP + V_SYNC);

   logic [9:0] hc_q, hc_d;
   logic [9:0] vc_q, vc_d;
   logic       hs_q, vs_q, blank_q, frame_start_q;
   logic [9:0] draw_x_q, draw_y_q;

   logic       h_wrap;
   logic       hs_d, vs_d, blank_d, at_origin;
   logic [10:0] hc_ext, vc_ext;

   always_comb begin
      hc_ext    = {1'b0, hc_q};
      vc_ext    = {1'b0, vc_q};
      h_wrap    = (hc_ext == H_TOTAL - 11'd1);
      hc_d      = h_wrap ? 10'd0 : hc_q + 10'd1;
      vc_d      = vc_q;
      if (h_wrap) begin
         vc_d = (vc_ext == V_TOTAL - 11'd1) ? 10'd0 : vc_q + 10'd1;
      end
      hs_d      = ~((hc_ext >= HS_START) && (hc_ext < HS_END));
      vs_d      = ~((vc_ext >= VS_START) && (vc_ext < VS_END));
      blank_d   = (hc_ext < H_VIS) && (vc_ext < V_VIS);
      at_origin = (hc_q == 10'd0) && (vc_q == 10'd0);
   end

   always_ff @(posedge vga_clk) begin
      if (reset) begin
         hc_q          <= '0;
         vc_q          <= '0;
         hs_q          <= 1'b1;
         vs_q          <= 1'b1;
         blank_q       <= 1'b0;
         draw_x_q      <= '0;
         draw_y_q      <= '0;
         frame_start_q <= 1'b0;
      end else if (pix_en) begin
         hc_q          <= hc_d;
         vc_q          <= vc_d;
         hs_q          <= hs_d;
         vs_q          <= vs_d;
         blank_q       <= blank_d;
         draw_x_q      <= hc_q;
         draw_y_q      <= vc_q;
         frame_start_q <= at_origin;
      end else begin
         // Stretched enables must not stretch the pulse.
         frame_start_q <= 1'b0;
      end
   end

   assign hs          = hs_q;
   assign vs          = vs_q;
   assign blank       = blank_q;
   assign DrawX       = draw_x_q;
   assign DrawY       = draw_y_q;
   assign frame_start = frame_start_q;

`ifdef VGA_FRAME_COUNT_EN
   logic [15:0] frame_count_q;
   logic        first_seen_q;

   // The frame that starts right after reset is frame 0; later frames count up.
   always_ff @(posedge vga_clk) begin
      if (reset) begin
         frame_count_q <= '0;
         first_seen_q  <= 1'b0;
      end else if (pix_en && at_origin) begin
         if (first_seen_q) begin
            frame_count_q <= frame_count_q + 16'd1;
         end
         first_seen_q <= 1'b1;
      end
   end

   assign frame_count = frame_count_q;
`else
   assign frame_count = '0;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Randomized bench for vga_timing_gen (small raster): linear-position reference model feeds a
// scoreboard queue that a monitor drains one entry per clock.
module tb_vga_timing_gen;

   localparam int HV = 16, HF = 4, HSY = 6, HB = 6;
   localparam int VV = 12, VF = 2, VSY = 2, VB = 3;
   localparam int HT = HV + HF + HSY + HB;
   localparam int VT = VV + VF + VSY + VB;
   localparam int FRAME = HT * VT;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        pix_en = 1'b1;
   logic        hs, vs, blank, frame_start;
   logic [9:0]  draw_x, draw_y;
   logic [15:0] frame_count;

   typedef struct {
      logic        hs;
      logic        vs;
      logic        blank;
      logic        fs;
      logic [9:0]  x;
      logic [9:0]  y;
      logic [15:0] fc;
   } exp_t;

   exp_t exp_q[$];
   exp_t cur;
   int   pos;
   bit   started;
   int   frames;
   int   phase;

   int n_checks = 0;
   int n_pass   = 0;

   vga_timing_gen #(
      .H_VISIBLE(HV), .H_FP(HF), .H_SYNC(HSY), .H_BP(HB),
      .V_VISIBLE(VV), .V_FP(VF), .V_SYNC(VSY), .V_BP(VB)
   ) dut (
      .vga_clk(clk),
      .reset(reset),
      .pix_en(pix_en),
      .hs(hs),
      .vs(vs),
      .blank(blank),
      .DrawX(draw_x),
      .DrawY(draw_y),
      .frame_start(frame_start),
      .frame_count(frame_count)
   );

   always #5 clk = ~clk;

   // One clock of stimulus; the model predicts what the outputs show after this posedge.
   task automatic step(input bit r, input bit en);
      int x, y;
      @(negedge clk);
      reset  = r;
      pix_en = en;
      if (r) begin
         pos     = 0;
         started = 0;
         frames  = 0;
         cur     = '{hs: 1'b1, vs: 1'b1, blank: 1'b0, fs: 1'b0, x: 10'd0, y: 10'd0, fc: 16'd0};
      end else if (en) begin
         x         = pos % HT;
         y         = pos / HT;
         cur.x     = 10'(x);
         cur.y     = 10'(y);
         cur.hs    = !(x >= HV + HF && x < HV + HF + HSY);
         cur.vs    = !(y >= VV + VF && y < VV + VF + VSY);
         cur.blank = (x < HV) && (y < VV);
         cur.fs    = (pos == 0);
         if (pos == 0) begin
            if (started) frames = (frames + 1) % 65536;
            started = 1;
         end
`ifdef VGA_FRAME_COUNT_EN
         cur.fc = 16'(frames);
`else
         cur.fc = 16'd0;
`endif
         pos = (pos + 1) % FRAME;
      end else begin
         cur.fs = 1'b0;
      end
      exp_q.push_back(cur);
   endtask

   task automatic check(input string name, input int got, input int want);
      n_checks++;
      if (got == want) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", name, got, want);
   endtask

   // Scoreboard monitor
   always begin
      exp_t e;
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         n_checks++;
         if (hs === e.hs && vs === e.vs && blank === e.blank && frame_start === e.fs &&
             draw_x === e.x && draw_y === e.y && frame_count === e.fc) begin
            n_pass++;
         end else begin
            $display("FAIL outputs @%0t: got hs=%b vs=%b blank=%b fs=%b x=%0d y=%0d fc=%0d expected hs=%b vs=%b blank=%b fs=%b x=%0d y=%0d fc=%0d",
                     $time, hs, vs, blank, frame_start, draw_x, draw_y, frame_count,
                     e.hs, e.vs, e.blank, e.fs, e.x, e.y, e.fc);
         end
      end
   end

   // Frame period and pulse-width checker, independent of the model.
   int  cyc = 0;
   int  last_pulse = 0;
   int  last_phase = 0;
   bit  prev_valid = 0;
   bit  prev_fs = 0;
   always begin
      @(posedge clk);
      #2;
      cyc++;
      if (reset) begin
         prev_valid = 0;
      end else if (frame_start === 1'b1) begin
         if (prev_fs) check("frame_start_width", 2, 1);
         if (prev_valid && last_phase == phase && (phase == 1 || phase == 2))
            check("frame_period", cyc - last_pulse, (phase == 1) ? FRAME : 2 * FRAME);
         last_pulse = cyc;
         last_phase = phase;
         prev_valid = 1;
      end
      prev_fs = (frame_start === 1'b1);
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int target, guard;
      phase = 0;
      cur = '{hs: 1'b1, vs: 1'b1, blank: 1'b0, fs: 1'b0, x: 10'd0, y: 10'd0, fc: 16'd0};
      pos = 0;
      started = 0;
      frames = 0;

      repeat (3) step(1, 1);
      phase = 1;
      repeat (3 * FRAME + 5) step(0, 1);

      phase = 2;
      for (int i = 0; i < 3 * FRAME; i++) begin
         step(0, 1);
         step(0, 0);
      end

      phase = 3;
      for (int i = 0; i < 2000; i++) begin
         step($urandom_range(0, 299) == 0, $urandom_range(0, 2) != 0);
      end

      // Reset while both syncs are active; outputs then show (21, 14).
      phase = 4;
      target = (VV + VF) * HT + (HV + HF + 2);
      guard = 0;
      while (pos != target && guard < 2 * FRAME) begin
         step(0, 1);
         guard++;
      end
      check("reach_sync_point", pos, target);
      step(0, 0);
      check("hs_active_before_reset", int'(hs), 0);
      check("vs_active_before_reset", int'(vs), 0);
      step(1, 1);
      repeat (FRAME + 10) step(0, 1);

      guard = 0;
      while (exp_q.size() > 0 && guard < 10) begin
         @(posedge clk);
         guard++;
      end
      #3;
      check("scoreboard_drained", exp_q.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
